// File: rtl/spi_alu_bridge_if.sv
// Bridge-to-ALU launch/complete bus: operands and start pulse out, done strobe with result/flags back.
// The master modport is the bridge side; the slave modport is the ALU side.
interface spi_alu_bridge_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [4:0]  alu_flags;

  modport master (
    output alu_a,
    output alu_b,
    output alu_start,
    input  alu_done,
    input  alu_result,
    input  alu_flags
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_start,
    output alu_done,
    output alu_result,
    output alu_flags
  );
endinterface

// File: rtl/spi_alu_bridge.sv
// Per SPI frame: latch operands on CS rise, run one ALU op under a timeout, commit {result,status}.
// Latency frame_end->commit >= 4 cycles; frames arriving while busy are dropped and flagged as overrun.
module spi_alu_bridge #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RESULT = 32'h7FC00000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    SPI_CS,
  input  logic [31:0]             operand1,
  input  logic [31:0]             operand2,
  spi_alu_bridge_if.master        alu,
  output logic [63:0]             alu_results,
  output logic                    busy
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  // CS synchroniser resets high so release from reset never looks like a frame end.
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   cs_dly_q;
  logic                   cs_synced;
  logic                   frame_end;

  assign cs_synced = cs_sync_q[SYNC_STAGES-1];
  assign frame_end = cs_synced & ~cs_dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync_q <= '1;
      cs_dly_q  <= 1'b1;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
      cs_dly_q  <= cs_synced;
    end
  end

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] lat_q, lat_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  flags_q, flags_d;
  logic        tmo_q, tmo_d;
  logic        ovr_q, ovr_d;
  logic [63:0] results_q, results_d;
  logic        busy_q, busy_d;

  logic [15:0] lat_inc;
  logic        limit_hit;

  assign lat_inc   = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
  assign limit_hit = (lat_inc == TMO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (alu.alu_done || limit_hit) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu.alu_start = (state_q == LAUNCH);
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    seq_d     = seq_q;
    lat_d     = lat_q;
    res_d     = res_q;
    flags_d   = flags_q;
    tmo_d     = tmo_q;
    ovr_d     = ovr_q;
    results_d = results_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (frame_end) begin
          a_d    = operand1;
          b_d    = operand2;
          seq_d  = seq_q + 8'd1;
          lat_d  = 16'd0;
          busy_d = 1'b1;
        end
      end
      LAUNCH: begin
        if (frame_end) ovr_d = 1'b1;
      end
      WAIT: begin
        if (frame_end) ovr_d = 1'b1;
        lat_d = lat_inc;
        // A done landing on the limit cycle still counts as a real completion.
        if (alu.alu_done) begin
          res_d   = alu.alu_result;
          flags_d = alu.alu_flags;
          tmo_d   = 1'b0;
        end else if (limit_hit) begin
          res_d   = TIMEOUT_RESULT;
          flags_d = 5'd0;
          tmo_d   = 1'b1;
        end
      end
      COMMIT: begin
        results_d = {res_q, seq_q, lat_q, tmo_q, ovr_q, 1'b0, flags_q};
        busy_d    = 1'b0;
        // A frame dropped on the commit cycle is reported with the following commit.
        ovr_d     = frame_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      seq_q     <= '0;
      lat_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      results_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      seq_q     <= seq_d;
      lat_q     <= lat_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      results_q <= results_d;
      busy_q    <= busy_d;
    end
  end

  assign alu.alu_a   = a_q;
  assign alu.alu_b   = b_q;
  assign alu_results = results_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_alu_bridge.sv
// Scoreboard bench for spi_alu_bridge: directed frames push expected launches/commits, a monitor compares.
module tb_spi_alu_bridge;

  logic        clk;
  logic        rst;
  logic        SPI_CS;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [63:0] alu_results;
  logic        busy;

  logic        mock_done;
  logic        stray_done;
  int          m_delay;
  logic [31:0] m_result;
  logic [4:0]  m_flags;

  int checks;
  int errors;

  logic [63:0] exp_res_q[$];
  logic [63:0] exp_start_q[$];

  spi_alu_bridge_if bus ();

  assign bus.alu_done   = mock_done | stray_done;
  assign bus.alu_result = m_result;
  assign bus.alu_flags  = m_flags;

  spi_alu_bridge #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_RESULT(32'h7FC00000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SPI_CS     (SPI_CS),
    .operand1   (operand1),
    .operand2   (operand2),
    .alu        (bus.master),
    .alu_results(alu_results),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Mock ALU: answers m_delay WAIT cycles after the launch pulse, never if m_delay is 0.
  initial begin
    int d;
    mock_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.alu_start && m_delay > 0) begin
        d = m_delay;
        repeat (d) @(negedge clk);
        mock_done = 1'b1;
        @(negedge clk);
        mock_done = 1'b0;
      end
    end
  end

  // Monitor: every launch and every commit must match the head of its queue.
  initial begin
    logic        busy_prev;
    logic [63:0] e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.alu_start) begin
          if (exp_start_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start actual=%h_%h expected=none", bus.alu_a, bus.alu_b);
          end else begin
            e = exp_start_q.pop_front();
            chk("start_operands", {bus.alu_a, bus.alu_b}, e);
          end
        end
        if (busy_prev && !busy) begin
          if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit actual=%h expected=none", alu_results);
          end else begin
            e = exp_res_q.pop_front();
            chk("commit_results", alu_results, e);
          end
        end
      end
      busy_prev = busy;
    end
  end

  task automatic send_frame(input logic [31:0] o1, input logic [31:0] o2);
    @(posedge clk); #2;
    SPI_CS   = 1'b0;
    operand1 = o1;
    operand2 = o2;
    repeat (3) @(posedge clk);
    #2;
    SPI_CS = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL %s_busy_rise actual=0 expected=1", name);
    end
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_busy_fall actual=1 expected=0", name);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [63:0] last;
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    SPI_CS     = 1'b1;
    operand1   = '0;
    operand2   = '0;
    stray_done = 1'b0;
    m_delay    = 0;
    m_result   = '0;
    m_flags    = '0;

    do_reset();
    chk("reset_results", alu_results, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_start", {63'h0, bus.alu_start}, 64'h0);
    chk("reset_alu_a", {32'h0, bus.alu_a}, 64'h0);

    // Basic operation: 1.0 + 2.0 = 3.0, done on the 5th WAIT cycle.
    m_delay = 5; m_result = 32'h40400000; m_flags = 5'd0;
    exp_start_q.push_back({32'h3F800000, 32'h40000000});
    exp_res_q.push_back(64'h40400000_01000500);
    send_frame(32'h3F800000, 32'h40000000);
    wait_done("basic");
    chk("basic_busy_after", {63'h0, busy}, 64'h0);

    // Timeout, then a normal frame.
    do_reset();
    m_delay = 0;
    exp_start_q.push_back({32'h01010101, 32'h02020202});
    exp_res_q.push_back(64'h7FC00000_01001080);
    send_frame(32'h01010101, 32'h02020202);
    wait_done("timeout");
    m_delay = 3; m_result = 32'h12345678; m_flags = 5'b00001;
    exp_start_q.push_back({32'h03030303, 32'h04040404});
    exp_res_q.push_back(64'h12345678_02000301);
    send_frame(32'h03030303, 32'h04040404);
    wait_done("after_timeout");

    // Overrun: second frame during WAIT is dropped and flagged on the first commit only.
    do_reset();
    m_delay = 12; m_result = 32'hC0C0C0C0; m_flags = 5'd0;
    exp_start_q.push_back({32'hA0000000, 32'hB0000000});
    exp_res_q.push_back(64'hC0C0C0C0_01000C40);
    send_frame(32'hA0000000, 32'hB0000000);
    repeat (4) @(posedge clk);
    send_frame(32'h11111111, 32'h22222222);
    repeat (4) @(posedge clk);
    #2;
    chk("overrun_alu_a_held", {32'h0, bus.alu_a}, 64'hA0000000);
    chk("overrun_alu_b_held", {32'h0, bus.alu_b}, 64'hB0000000);
    wait_done("overrun");
    m_delay = 2; m_result = 32'h55555555; m_flags = 5'd0;
    exp_start_q.push_back({32'h33333333, 32'h44444444});
    exp_res_q.push_back(64'h55555555_02000200);
    send_frame(32'h33333333, 32'h44444444);
    wait_done("after_overrun");

    // Done on exactly the limit cycle wins over timeout.
    do_reset();
    m_delay = 16; m_result = 32'h3F000000; m_flags = 5'b10000;
    exp_start_q.push_back({32'h0000AAAA, 32'h0000BBBB});
    exp_res_q.push_back(64'h3F000000_01001010);
    send_frame(32'h0000AAAA, 32'h0000BBBB);
    wait_done("race");

    // Reset mid-WAIT; the late done must be ignored.
    do_reset();
    m_delay = 10; m_result = 32'hFFFFFFFF; m_flags = 5'b11111;
    exp_start_q.push_back({32'h00000001, 32'h00000002});
    send_frame(32'h00000001, 32'h00000002);
    begin
      int n;
      n = 0;
      while (!busy && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    chk("rst_mid_results", alu_results, 64'h0);
    chk("rst_mid_busy", {63'h0, busy}, 64'h0);
    chk("rst_mid_alu_a", {32'h0, bus.alu_a}, 64'h0);
    m_delay = 1; m_result = 32'h0BADF00D; m_flags = 5'd0;
    exp_start_q.push_back({32'h00000005, 32'h00000006});
    exp_res_q.push_back(64'h0BADF00D_01000100);
    send_frame(32'h00000005, 32'h00000006);
    wait_done("after_rst_mid");

    // 256 frames: the sequence number wraps to 0x00 on the last one.
    do_reset();
    m_delay = 1; m_flags = 5'd0;
    last = '0;
    for (int i = 0; i < 256; i++) begin
      m_result = 32'(i);
      last = {32'(i), 8'(i + 1), 16'h0001, 8'h00};
      exp_start_q.push_back({32'(i), ~32'(i)});
      exp_res_q.push_back(last);
      send_frame(32'(i), ~32'(i));
      wait_done("seq_wrap");
    end
    chk("wrap_last_seq", {56'h0, alu_results[31:24]}, 64'h0);

    // Stray done while IDLE leaves the committed value alone.
    m_result = 32'hDEADBEEF;
    @(posedge clk); #2;
    stray_done = 1'b1;
    @(posedge clk); #2;
    stray_done = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("stray_done_results", alu_results, last);
    chk("stray_done_busy", {63'h0, busy}, 64'h0);

    repeat (5) @(posedge clk);
    chk("res_queue_drained", 64'(exp_res_q.size()), 64'h0);
    chk("start_queue_drained", 64'(exp_start_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_alu_bridge.md
Name: spi_alu_bridge

Overview:
- Sits between the SPI slave and the floating-point ALU.
- On completion of each 64-bit SPI frame (chip-select rising edge), latches `operand1`/`operand2` and launches one ALU operation with a start/done handshake, guarded by a timeout.
- Packs the ALU result and a status word into the 64-bit `alu_results` register that the SPI slave shifts out on the next frame.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising SPI_CS into clk domain (min 2).
- TIMEOUT_CYCLES, 1024: WAIT cycles allowed before the operation is aborted (min 2, max 65535).
- TIMEOUT_RESULT, 32'h7FC00000: value reported as result on timeout (fp32 quiet NaN).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- SPI_CS  input  1  raw SPI chip select (active low), asynchronous to clk.
- operand1  input  32  first operand from SPI slave, stable from CS rise until next CS fall.
- operand2  input  32  second operand from SPI slave, same stability.
- alu_a  output  32  latched operand A to ALU.
- alu_b  output  32  latched operand B to ALU.
- alu_start  output  1  one-cycle launch pulse to ALU.
- alu_done  input  1  ALU completion strobe, one cycle.
- alu_result  input  32  ALU result, valid when alu_done=1.
- alu_flags  input  5  ALU exception flags {NV,DZ,OF,UF,NX}, valid with alu_done.
- alu_results  output  64  packed {result[31:0], status[31:0]} to SPI slave.
- busy  output  1  high from frame capture until commit.

Behaviour:
- Reset (rst=0, async): all CS sync flops=1, state=IDLE, alu_a=alu_b=0, alu_start=0, alu_results=0, busy=0, seq=0, overrun=0, latency counter=0.
- CS sync: SYNC_STAGES-flop chain plus one delay flop; frame_end = synced CS 0->1 edge, one-cycle pulse. Reset values of 1 guarantee no spurious edge after reset.
- Status word:
  - [31:24] seq, an 8-bit frame counter for the frame being reported; wraps 0xFF->0x00.
  - [23:8] latency, the WAIT cycles counted, saturating at 0xFFFF.
  - [7] timeout.
  - [6] overrun.
  - [5] 0.
  - [4:0] flags.
- FSM states: IDLE, LAUNCH, WAIT, COMMIT.
  - IDLE, frame_end=1: alu_a<=operand1, alu_b<=operand2, seq<=seq+1, latency<=0, busy<=1. Next LAUNCH.
  - LAUNCH: alu_start=1 for exactly this cycle. Next WAIT.
  - WAIT: latency increments every cycle including the cycle alu_done is seen.
    - alu_done=1: capture alu_result and alu_flags, timeout bit=0. Next COMMIT.
    - No done and latency reaches TIMEOUT_CYCLES: result=TIMEOUT_RESULT, flags=0, timeout bit=1. Next COMMIT.
    - Done in the same cycle the limit is reached: done wins.
  - COMMIT: alu_results <= {result, status}, overrun bit = sticky overrun, overrun cleared, busy<=0. Next IDLE.
- alu_results changes only in COMMIT and is otherwise held, so the SPI slave never sees a torn value.
- frame_end while not IDLE: frame dropped (operands not latched, seq unchanged), sticky overrun set. A frame_end coinciding with COMMIT is also dropped and sets overrun for the *next* commit.
- alu_done outside WAIT is ignored.
- Reset asserted mid-operation: immediate return to reset values; an in-flight ALU done after reset release is ignored (state IDLE).
- Throughput: one operation per frame; minimum frame_end-to-commit latency is 4 cycles with a 1-cycle ALU.

Test Plan:
- Basic op: reset, SPI frame with operand1=0x3F800000, operand2=0x40000000; mock ALU asserts done on 5th WAIT cycle with result 0x40400000, flags 0 -> alu_start pulses once with alu_a/alu_b equal to operands; alu_results=0x40400000_01000500; busy low after commit.
- Timeout: TIMEOUT_CYCLES=16, mock ALU never responds -> after 16 WAIT cycles alu_results=0x7FC00000_01001080, busy drops, next frame accepted normally (seq=0x02).
- Overrun: second CS pulse during WAIT of frame 1 (operand1=0x11111111) -> alu_a unchanged, only one alu_start; frame 1 status bit6=1; following frame status bit6=0, seq=0x02.
- Flags/done-vs-timeout race: done asserted exactly at cycle TIMEOUT_CYCLES with flags 5'b10000 -> timeout bit 0, status[4:0]=0x10, result from ALU.
- Reset mid-WAIT: assert rst during WAIT, then mock asserts alu_done after release -> alu_results=0, seq=0, no commit; next frame reports seq=0x01.
- Seq wrap and stray done: 256 frames -> 256th status seq=0x00; alu_done pulse while IDLE -> alu_results unchanged.
